uart_rx_tx: RTL and testbench
=============================

UART_RX_TX -- requirements
Module: uart_rx_tx

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 191, meaning clk_in cycles per UART bit (22 MHz / 191 = 115183 baud); legal range 4..65535.
REQ-002 SHALL have port clk_in, input, 1, system clock.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous, active-high.
REQ-004 SHALL have port i_enable, input, 1, receiver enable.
REQ-005 SHALL have port i_rx, input, 1, asynchronous serial receive line, idle high.
REQ-006 SHALL have port o_rxdata, output, 8, last correctly framed received byte.
REQ-007 SHALL have port o_recvdata, output, 1, one-cycle pulse marking a new byte in o_rxdata.
REQ-008 SHALL have port o_rx_busy, output, 1, high while a frame is being received.
REQ-009 SHALL have port i_start, input, 1, transmit request.
REQ-010 SHALL have port i_data, input, 8, byte to transmit.
REQ-011 SHALL have port o_done, output, 1, one-cycle pulse at end of a transmitted frame.
REQ-012 SHALL have port o_tx_busy, output, 1, transmitter busy.
REQ-013 SHALL have port o_dout, output, 1, serial transmit line.

Function
REQ-014 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit, each TICKS_PER_BIT cycles long.
REQ-015 The receiver SHALL pass i_rx through a two-flop synchronizer before any use.
REQ-016 The receiver SHALL use states IDLE, START, DATA, STOP; IDLE->START on a synchronized low with i_enable=1; with i_enable=0 it SHALL remain in IDLE.
REQ-017 In START, it SHALL resample at TICKS_PER_BIT/2 cycles (integer division); a high sample SHALL count as a glitch and return to IDLE with no output change.
REQ-018 The receiver SHALL sample each data bit and the stop bit every TICKS_PER_BIT cycles after the start-bit midpoint, shifting bits in LSB first.
REQ-019 On a high stop sample, it SHALL load o_rxdata and pulse o_recvdata high for exactly 1 cycle in the same cycle; on a low stop sample (framing error), it SHALL discard the byte, hold o_rxdata, and not pulse.
REQ-020 o_rx_busy SHALL be high from leaving IDLE until the return to IDLE; the receiver SHALL accept a new start bit on the cycle after returning to IDLE.
REQ-021 Deasserting i_enable mid-frame SHALL NOT abort the frame in progress.
REQ-022 The transmitter SHALL use states IDLE, START, DATA, STOP; in IDLE, o_dout=1 and o_tx_busy=0.
REQ-023 When i_start=1 in IDLE, the transmitter SHALL latch i_data and enter START on the next edge.
REQ-024 o_tx_busy SHALL go high combinationally in the same cycle i_start is high in IDLE, and SHALL stay high until the cycle after the stop bit ends.
REQ-025 o_dout SHALL be driven from a register with no glitches: start low for TICKS_PER_BIT cycles, then data[0]..data[7], then stop high.
REQ-026 At the end of the stop bit, the transmitter SHALL pulse o_done for 1 cycle and return to IDLE.
REQ-027 i_start while busy SHALL be ignored; i_start held high SHALL send back-to-back frames with exactly one full stop bit between them.
REQ-028 Bit counters SHALL be $clog2(TICKS_PER_BIT)+1 bits wide and SHALL NOT wrap before terminal count.

Reset
REQ-029 On reset, both FSMs SHALL go to IDLE, with o_dout=1, o_tx_busy=0, o_done=0, o_rx_busy=0, o_recvdata=0, o_rxdata=8'h00, and the synchronizer flops set to 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no o_done or o_recvdata pulse.

Configuration
REQ-031 Macro UART_LOOPBACK_EN: when defined, the receiver input SHALL be o_dout internally and i_rx SHALL be ignored; when undefined, the receiver SHALL use i_rx.

Verification (TICKS_PER_BIT=16 unless noted)
REQ-032 i_start pulse with i_data=8'hA5 -> o_dout = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; o_done pulses once at cycle 160; o_tx_busy high in the i_start cycle.
REQ-033 Drive 8'h0A frame on i_rx -> o_rxdata=8'h0A with a 1-cycle o_recvdata pulse; o_rx_busy falls afterwards.
REQ-034 Stop bit low on i_rx with data 8'h3C -> no o_recvdata pulse; o_rxdata holds its previous value.
REQ-035 4-cycle low glitch on i_rx -> receiver returns to IDLE; o_rx_busy pulses briefly; no data output.
REQ-036 Assert reset at bit 4 of a TX frame -> o_dout=1 and o_tx_busy=0 immediately; a subsequent i_start with 8'h55 transmits correctly.
REQ-037 With UART_LOOPBACK_EN defined, TX 8'hC3 -> o_rxdata=8'hC3 with an o_recvdata pulse; i_rx held low has no effect.

Source files
------------

// File: rtl/uart_rx_tx.sv
// 8N1 UART receiver and transmitter sharing one clock and bit-period parameter.
// Define UART_LOOPBACK_EN to feed the receiver from o_dout instead of i_rx.
module uart_rx_tx #(
    parameter int TICKS_PER_BIT = 191
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_rx,
    output logic [7:0] o_rxdata,
    output logic       o_recvdata,
    output logic       o_rx_busy,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_done,
    output logic       o_tx_busy,
    output logic       o_dout
);

    localparam int CW = $clog2(TICKS_PER_BIT) + 1;
    localparam logic [CW-1:0] TERM      = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TERM = CW'(TICKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- receiver ----------------
    logic          rx_line;
    logic          rx_meta;
    logic          rx_sync;
    state_t        rx_state;
    state_t        rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_half;
    logic          rx_full;

`ifdef UART_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = i_rx;
    assign rx_line   = o_dout;
`else
    assign rx_line   = i_rx;
`endif

    // Synchronizer idles high so reset never looks like a start bit
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_sync <= rx_meta;
        end
    end

    assign rx_half = (rx_cnt == HALF_TERM);
    assign rx_full = (rx_cnt == TERM);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) rx_state <= IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (i_enable && !rx_sync) rx_next = START;
            START:   if (rx_half) rx_next = rx_sync ? IDLE : DATA;
            DATA:    if (rx_full && rx_bit == 3'd7) rx_next = STOP;
            STOP:    if (rx_full) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        o_rx_busy = (rx_state != IDLE);
    end

    // Counter restarts at the start-bit midpoint so later samples land mid-bit
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            o_rxdata   <= '0;
            o_recvdata <= 1'b0;
        end else begin
            o_recvdata <= 1'b0;
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
                DATA: begin
                    rx_cnt <= rx_full ? '0 : rx_cnt + 1'b1;
                    if (rx_full) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                    end
                end
                STOP: begin
                    rx_cnt <= rx_full ? '0 : rx_cnt + 1'b1;
                    if (rx_full && rx_sync) begin
                        o_rxdata   <= rx_shift;
                        o_recvdata <= 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    state_t        tx_state;
    state_t        tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_full;

    assign tx_full = (tx_cnt == TERM);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) tx_state <= IDLE;
        else       tx_state <= tx_next;
    end

    // A held i_start chains straight from stop into the next start bit
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    if (i_start) tx_next = START;
            START:   if (tx_full) tx_next = DATA;
            DATA:    if (tx_full && tx_bit == 3'd7) tx_next = STOP;
            STOP:    if (tx_full) tx_next = i_start ? START : IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        o_tx_busy = (tx_state != IDLE) || i_start;
        o_done    = (tx_state == STOP) && tx_full;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            o_dout   <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (i_start) begin
                        tx_shift <= i_data;
                        o_dout   <= 1'b0;
                    end
                end
                START: begin
                    tx_cnt <= tx_full ? '0 : tx_cnt + 1'b1;
                    if (tx_full) o_dout <= tx_shift[0];
                end
                DATA: begin
                    tx_cnt <= tx_full ? '0 : tx_cnt + 1'b1;
                    if (tx_full) begin
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        o_dout   <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                    end
                end
                STOP: begin
                    tx_cnt <= tx_full ? '0 : tx_cnt + 1'b1;
                    if (tx_full) begin
                        o_dout <= 1'b1;
                        if (i_start) begin
                            tx_shift <= i_data;
                            tx_bit   <= '0;
                            o_dout   <= 1'b0;
                        end
                    end
                end
                default: begin
                    tx_cnt <= '0;
                    o_dout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Scoreboard bench for uart_rx_tx at 16 ticks per bit; expected bytes are queued
// when driven and compared by the RX-pulse monitor and an independent TX line decoder.
module tb_uart_rx_tx;

    localparam int T = 16;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_rxdata;
    logic       o_recvdata;
    logic       o_rx_busy;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_done;
    logic       o_tx_busy;
    logic       o_dout;

    uart_rx_tx #(.TICKS_PER_BIT(T)) dut (
        .clk_in(clk_in), .reset(reset), .i_enable(i_enable), .i_rx(i_rx),
        .o_rxdata(o_rxdata), .o_recvdata(o_recvdata), .o_rx_busy(o_rx_busy),
        .i_start(i_start), .i_data(i_data), .o_done(o_done),
        .o_tx_busy(o_tx_busy), .o_dout(o_dout)
    );

    always #5 clk_in = ~clk_in;

    int assertCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    int rxPulseCount = 0;
    int doneCount = 0;
    int lastDoneCycle = 0;
    int prevDoneCycle = 0;
    logic lastRecv = 1'b0;
    logic rxBusySeen = 1'b0;
    logic txAbort = 1'b0;
    logic [7:0] rxQueue[$];
    logic [7:0] txQueue[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    always @(posedge clk_in) cycleCount++;

    // RX scoreboard: every o_recvdata pulse must match the oldest queued byte
    always @(negedge clk_in) begin
        if (o_rx_busy) rxBusySeen = 1'b1;
        if (o_done) begin
            doneCount++;
            prevDoneCycle = lastDoneCycle;
            lastDoneCycle = cycleCount;
        end
        if (o_recvdata === 1'b1) begin
            rxPulseCount++;
            checkOutput("rx_pulse_prev_low", {31'b0, lastRecv}, 0);
            checkOutput("rx_expected_pending", {31'b0, rxQueue.size() > 0}, 1);
            if (rxQueue.size() > 0) checkOutput("rx_byte", {24'b0, o_rxdata}, {24'b0, rxQueue.pop_front()});
        end
        lastRecv = o_recvdata;
    end

    always @(posedge reset) txAbort = 1'b1;

    // TX decoder: find a start bit, sample each bit at its middle, compare the frame
    initial begin : txDecoder
        logic [8:0] frame;
        forever begin
            @(negedge clk_in);
            if (reset === 1'b0 && o_dout === 1'b0) begin
                txAbort = 1'b0;
                repeat (T / 2 - 1) @(negedge clk_in);
                for (int i = 0; i < 9; i++) begin
                    repeat (T) @(negedge clk_in);
                    frame[i] = o_dout;
                end
                if (!txAbort) begin
                    checkOutput("tx_expected_pending", {31'b0, txQueue.size() > 0}, 1);
                    if (txQueue.size() > 0) checkOutput("tx_frame", {23'b0, frame}, {23'b0, 1'b1, txQueue.pop_front()});
                end
            end
        end
    end

    task automatic expectTx(input logic [7:0] d);
        txQueue.push_back(d);
`ifdef UART_LOOPBACK_EN
        rxQueue.push_back(d);
`endif
    endtask

    task automatic driveRxBit(input logic b);
        i_rx = b;
        repeat (T) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic dropEnable);
        if (stopBit && i_enable) rxQueue.push_back(d);
        driveRxBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveRxBit(d[i]);
            if (dropEnable && i == 0) i_enable = 1'b0;
        end
        driveRxBit(stopBit);
        i_rx = 1'b1;
        i_enable = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while ((rxQueue.size() > 0 || txQueue.size() > 0) && n < maxCycles) begin
            @(posedge clk_in);
            n++;
        end
        #1;
        checkOutput("drain_pending", rxQueue.size() + txQueue.size(), 0);
    endtask

    task automatic waitDone(input int target, input int maxCycles);
        int n = 0;
        while (doneCount < target && n < maxCycles) begin
            @(posedge clk_in);
            n++;
        end
        checkOutput("done_reached", {31'b0, doneCount >= target}, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base;
        logic [7:0] held;
        logic expBit;
`ifdef UART_LOOPBACK_EN
        i_rx = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        checkOutput("rst_dout", {31'b0, o_dout}, 1);
        checkOutput("rst_tx_busy", {31'b0, o_tx_busy}, 0);
        checkOutput("rst_done", {31'b0, o_done}, 0);
        checkOutput("rst_rx_busy", {31'b0, o_rx_busy}, 0);
        checkOutput("rst_recvdata", {31'b0, o_recvdata}, 0);
        checkOutput("rst_rxdata", {24'b0, o_rxdata}, 0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        i_enable = 1'b1;
        idleCycles(5);

`ifndef UART_LOOPBACK_EN
        // Receiver: clean frame, disabled receiver, framing error, glitch, enable drop
        applyStimulus(8'h0A, 1'b1, 1'b0);
        idleCycles(10);
        waitDrain(100);
        checkOutput("rx_busy_after", {31'b0, o_rx_busy}, 0);
        checkOutput("rx_hold_0A", {24'b0, o_rxdata}, 32'h0A);

        base = rxPulseCount;
        rxBusySeen = 1'b0;
        i_enable = 1'b0;
        applyStimulus(8'h55, 1'b1, 1'b0);
        idleCycles(20);
        checkOutput("rx_disabled_pulses", rxPulseCount, base);
        checkOutput("rx_disabled_busy", {31'b0, rxBusySeen}, 0);

        base = rxPulseCount;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idleCycles(40);
        checkOutput("rx_frame_err_pulses", rxPulseCount, base);
        checkOutput("rx_frame_err_hold", {24'b0, o_rxdata}, 32'h0A);
        checkOutput("rx_frame_err_idle", {31'b0, o_rx_busy}, 0);

        base = rxPulseCount;
        rxBusySeen = 1'b0;
        i_rx = 1'b0;
        idleCycles(4);
        i_rx = 1'b1;
        idleCycles(30);
        checkOutput("rx_glitch_busy_seen", {31'b0, rxBusySeen}, 1);
        checkOutput("rx_glitch_idle", {31'b0, o_rx_busy}, 0);
        checkOutput("rx_glitch_pulses", rxPulseCount, base);
        checkOutput("rx_glitch_hold", {24'b0, o_rxdata}, 32'h0A);

        applyStimulus(8'hC7, 1'b1, 1'b1);
        idleCycles(10);
        waitDrain(100);
`else
        // Loopback: transmitted byte comes back through the receiver; i_rx stays low
        base = rxPulseCount;
        expectTx(8'hC3);
        i_data = 8'hC3;
        i_start = 1'b1;
        idleCycles(1);
        i_start = 1'b0;
        waitDrain(400);
        checkOutput("lb_rxdata", {24'b0, o_rxdata}, 32'hC3);
        checkOutput("lb_pulses", rxPulseCount, base + 1);
        idleCycles(20);
`endif

        // Transmitter: cycle-accurate A5 frame with an ignored mid-frame request
        base = doneCount;
        held = 8'hA5;
        @(posedge clk_in);
        #1;
        i_data = held;
        i_start = 1'b1;
        expectTx(held);
        @(negedge clk_in);
        checkOutput("tx_busy_start_cycle", {31'b0, o_tx_busy}, 1);
        for (int c = 1; c <= 161; c++) begin
            @(posedge clk_in);
            #1;
            i_start = (c == 50);
            i_data = (c == 50) ? 8'hFF : held;
            @(negedge clk_in);
            if (c <= 160 && ((c - 1) % T == 0 || c % T == 0)) begin
                int k;
                k = (c - 1) / T;
                expBit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : held[k - 1];
                checkOutput($sformatf("tx_a5_c%0d", c), {31'b0, o_dout}, {31'b0, expBit});
            end
            if (c >= 159) checkOutput($sformatf("tx_done_c%0d", c), {31'b0, o_done}, {31'b0, c == 160});
        end
        checkOutput("tx_busy_after", {31'b0, o_tx_busy}, 0);
        checkOutput("tx_a5_done_count", doneCount, base + 1);
        idleCycles(30);
        waitDrain(200);

        // Back-to-back frames with i_start held: done pulses exactly one frame apart
        base = doneCount;
        i_data = 8'h81;
        i_start = 1'b1;
        expectTx(8'h81);
        idleCycles(1);
        i_data = 8'h7E;
        expectTx(8'h7E);
        waitDone(base + 1, 400);
        #1;
        i_start = 1'b0;
        waitDone(base + 2, 400);
        checkOutput("tx_b2b_interval", lastDoneCycle - prevDoneCycle, 10 * T);
        idleCycles(30);
        waitDrain(200);

        // Reset during data bit 4 aborts immediately, then 55 goes out cleanly
        base = doneCount;
        i_data = 8'h5A;
        i_start = 1'b1;
        idleCycles(1);
        i_start = 1'b0;
        idleCycles(1 + 4 * T + 6);
        reset = 1'b1;
        @(negedge clk_in);
        checkOutput("rst_mid_dout", {31'b0, o_dout}, 1);
        checkOutput("rst_mid_tx_busy", {31'b0, o_tx_busy}, 0);
        idleCycles(3);
        reset = 1'b0;
        idleCycles(100);
        checkOutput("rst_mid_no_done", doneCount, base);
        i_data = 8'h55;
        i_start = 1'b1;
        expectTx(8'h55);
        idleCycles(1);
        i_start = 1'b0;
        idleCycles(10 * T + 20);
        waitDrain(200);
        checkOutput("post_rst_done", doneCount, base + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
